// File: rtl/wb_sram_ctrl_pkg.sv
// Shared types and constants for the Wishbone-to-async-SRAM controller.
package wb_sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_ACK
  } state_e;

  localparam int SRAM_ADDR_W = 20;
  localparam int RD_WAIT_DEF = 2;
  localparam int WR_WAIT_DEF = 2;

  localparam logic       EN_N    = 1'b0;
  localparam logic       DIS_N   = 1'b1;
  localparam logic [3:0] BE_NONE = 4'hF;
  localparam logic [3:0] BE_ALL  = 4'h0;

  // Wait counter only ever holds (wait-1), so clog2 of the larger wait suffices.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave driving an external asynchronous 32-bit SRAM with
// programmable read/write wait states. Every output comes straight from a flop.
module wb_sram_ctrl
  import wb_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int WR_WAIT = WR_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_addr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_data_i,
  output logic [31:0]       wb_data_o,
  output logic              wb_ack_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_dq_o,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int CNT_W = cnt_width(RD_WAIT, WR_WAIT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic [3:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       dq_o_q, dq_o_d;
  logic [31:0]       data_o_q, data_o_d;
  logic              ack_q, ack_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [3:0]        be_n_q, be_n_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{wb_addr_i[31:ADDR_W+2], wb_addr_i[1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    abort_d  = abort_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    dq_o_d   = dq_o_q;
    data_o_d = data_o_q;

    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (wb_cyc_i && wb_stb_i) begin
          addr_d = wb_addr_i[ADDR_W+1:2];
          if (wb_we_i) begin
            state_d = ST_WR_SETUP;
            dq_o_d  = wb_data_i;
            sel_d   = wb_sel_i;
          end else begin
            state_d = ST_READ;
            cnt_d   = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      ST_READ: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          data_o_d = sram_dq_i;
          state_d  = ST_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WR_SETUP: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR_PULSE;
          cnt_d   = CNT_W'(WR_WAIT - 1);
        end
      end
      ST_WR_PULSE: begin
        // An abort here still passes through WR_HOLD so we_n rises before data is released.
        if (!wb_cyc_i) begin
          state_d = ST_WR_HOLD;
          abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WR_HOLD: state_d = (abort_q || !wb_cyc_i) ? ST_IDLE : ST_ACK;
      ST_ACK:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    ack_d   = 1'b0;
    dq_oe_d = 1'b0;
    ce_n_d  = DIS_N;
    oe_n_d  = DIS_N;
    we_n_d  = DIS_N;
    be_n_d  = BE_NONE;
    unique case (state_d)
      ST_READ: begin
        ce_n_d = EN_N;
        oe_n_d = EN_N;
        be_n_d = BE_ALL;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        ce_n_d  = EN_N;
        dq_oe_d = 1'b1;
        be_n_d  = ~sel_d;
      end
      ST_WR_PULSE: begin
        ce_n_d  = EN_N;
        dq_oe_d = 1'b1;
        be_n_d  = ~sel_d;
        we_n_d  = (sel_d == 4'h0) ? DIS_N : EN_N;
      end
      ST_ACK:  ack_d = 1'b1;
      default: ack_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
      sel_q    <= 4'h0;
      addr_q   <= '0;
      dq_o_q   <= '0;
      data_o_q <= '0;
      ack_q    <= 1'b0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= DIS_N;
      oe_n_q   <= DIS_N;
      we_n_q   <= DIS_N;
      be_n_q   <= BE_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      dq_o_q   <= dq_o_d;
      data_o_q <= data_o_d;
      ack_q    <= ack_d;
      dq_oe_q  <= dq_oe_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      be_n_q   <= be_n_d;
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_data_o   = data_o_q;
  assign sram_addr_o = addr_q;
  assign sram_dq_o   = dq_o_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_be_n   = be_n_q;

endmodule

// File: doc/wb_sram_ctrl.md
Name: wb_sram_ctrl

Overview:
Wishbone classic slave that sits directly downstream of the CPU's Wishbone master port on the SoC bus. It turns one 32-bit Wishbone read or write into a timed access on an external asynchronous 32-bit SRAM, using a configurable number of wait states. It returns read data and a single-cycle ack. The bus master inserts no turnaround of its own, so this block owns all SRAM strobe sequencing.

Parameters:
ADDR_W, 20, SRAM word-address width; taken from wb_addr_i[ADDR_W+1:2].
RD_WAIT, 2, cycles ce_n/oe_n are held low before read data is captured (minimum 1).
WR_WAIT, 2, cycles we_n is held low during a write (minimum 1).

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-low reset.
wb_cyc_i  in  1  bus cycle valid.
wb_stb_i  in  1  strobe; a request is cyc & stb.
wb_we_i  in  1  1 = write, 0 = read.
wb_addr_i  in  32  byte address; bits [1:0] are ignored.
wb_sel_i  in  4  byte lanes for writes.
wb_data_i  in  32  write data.
wb_data_o  out  32  read data; registered.
wb_ack_o  out  1  single-cycle completion pulse.
sram_addr_o  out  ADDR_W  SRAM word address.
sram_dq_o  out  32  data driven to the SRAM.
sram_dq_i  in  32  data from the SRAM.
sram_dq_oe  out  1  pad output enable (1 = drive sram_dq_o).
sram_ce_n  out  1  chip enable, active-low.
sram_oe_n  out  1  output enable, active-low.
sram_we_n  out  1  write enable, active-low.
sram_be_n  out  4  byte enables, active-low.

Behaviour:
- Reset values (async, while rst = 0): wb_ack_o=0, wb_data_o=0, sram_addr_o=0, sram_dq_o=0, sram_dq_oe=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=4'hF, state=IDLE, counter=0.
- All outputs are registered; no combinational path from wb_* inputs to any output.
- Reset asserted mid-operation: every output returns to its reset value at once. No ack is produced for the aborted access.
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- IDLE:
  - On an edge with cyc & stb, latch the address and go to READ or WR_SETUP according to wb_we_i.
  - For a write, also latch wb_data_i and wb_sel_i.
  - Otherwise strobes stay inactive.
- READ:
  - ce_n=0, oe_n=0, be_n=4'h0, dq_oe=0.
  - Counter runs RD_WAIT cycles.
  - On the last cycle, capture sram_dq_i into wb_data_o and go to ACK.
- WR_SETUP (1 cycle): ce_n=0, oe_n=1, dq_oe=1, dq_o and addr valid, we_n=1, be_n=~sel. Then go to WR_PULSE.
- WR_PULSE (WR_WAIT cycles): we_n=0, all else unchanged. Then go to WR_HOLD.
- WR_HOLD (1 cycle): we_n=1; data, address and be_n still held for hold time. Then go to ACK.
- ACK (1 cycle): wb_ack_o=1; ce_n, oe_n and we_n all 1; dq_oe=0. Next state is IDLE.
- Latency, with N = the cycle in which cyc & stb is first seen in IDLE:
  - Read: ack is high in cycle N+1+RD_WAIT (N+3 with defaults).
  - Write: ack is high in cycle N+3+WR_WAIT (N+5 with defaults).
- Back-to-back requests: IDLE always lasts at least one cycle after ACK. A master still holding stb is treated as a new request on that IDLE edge.
- wb_data_o holds the last read value until the next read capture. Writes do not change it.
- Write with wb_sel_i=4'h0: the full sequence runs and is acked, but we_n never goes low.
- Abort (cyc_i=0 while busy):
  - In READ or WR_SETUP: go to IDLE next edge and deassert all strobes. No ack, no SRAM modification.
  - In WR_PULSE: go to WR_HOLD (we_n rises cleanly), then IDLE. No ack.
  - In WR_HOLD: go to IDLE, no ack.
- The counter is sized by clog2 of max(RD_WAIT, WR_WAIT). It reloads on every state entry and never wraps mid-state.
- sram_dq_oe is never 1 while sram_oe_n=0 (bus-contention invariant).

Decomposition:
- Shared defines file (alongside defines.v): state encodings, SramAddrBus width, default wait-state constants, active-low enable/disable constants.
- No sub-module. The FSM and wait counter form one cohesive block; the tristate pad stays in the board top level.

Test Plan:
- Reset, then a read at 0x0000_0010 with the model word 0xDEADBEEF -> sram_addr_o=0x4 and ce_n/oe_n low in cycles N+1..N+2; wb_ack_o=1 and wb_data_o=0xDEADBEEF in cycle N+3 only.
- Write 0x12345678 to 0x0000_0020 with sel=4'b0011 -> we_n low exactly 2 cycles (N+2..N+3) with be_n=4'b1100. Ack in N+5. A read-back returns the old upper half and 0x5678 in the lower half.
- Write with sel=0 -> we_n stays 1 throughout; ack in N+5; the SRAM word is unchanged.
- Drop cyc_i during WR_PULSE -> we_n rises the next cycle, then dq_oe=0 and state IDLE; no ack at any point.
- Back-to-back: stb held high through the ack of a read, followed by a write -> exactly one IDLE cycle between them. Verify sram_dq_oe never overlaps oe_n=0.
- Pull rst low during READ -> all outputs return to reset values immediately, and no ack is seen after rst is released.
